mem_line_arbiter: RTL and testbench
===================================

// Module: mem_line_arbiter
// PURPOSE
//  Shares one line-wide memory read port between NUM_REQ cache-refill requesters (icache, prefetcher, ...).
//  Round-robin (or fixed-priority) grant; one outstanding memory transaction at a time.
//  Requester side speaks the cache refill handshake: valid held until a 1-cycle ready pulse; rdata sampled on that pulse.
//  Sits between the cache refill ports and the memory/bus model.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  LINE_WIDTH  64  bits per line transfer (8*BLOCK_SIZE*NUM_BLOCKS)
//  ADDR_WIDTH  32  request address width
//  FIXED_PRIO  0   0 = round-robin; 1 = fixed priority, lowest index wins
// PORTS
//  clk         in   1                   clock
//  resetn      in   1                   async active-low reset
//  req_valid   in   NUM_REQ             per-requester line read request
//  req_addr    in   NUM_REQ*ADDR_WIDTH  flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_ready   out  NUM_REQ             1-cycle completion pulse to the granted requester
//  req_rdata   out  LINE_WIDTH          line data, broadcast to all; valid only with req_ready
//  mem_valid   out  1                   memory request
//  mem_addr    out  ADDR_WIDTH          memory address, latched at grant
//  mem_ready   in   1                   memory completion pulse; mem_rdata valid this cycle
//  mem_rdata   in   LINE_WIDTH          memory line data
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, mem_valid=0, mem_addr=0, grant=0, rr_ptr=0; req_ready=0 (comb.).
//  States: IDLE, BUSY, ABORT, DRAIN.
//  IDLE: if any req_valid: pick winner (RR: first valid at or after rr_ptr, wrapping; FIXED: lowest index).
//    Register grant, mem_addr<=req_addr[winner] unmodified, mem_valid<=1 -> BUSY. First mem_valid 1 cycle after req_valid.
//  BUSY: req_ready[grant] = mem_ready (comb., same cycle); req_rdata = mem_rdata (pass-through, all cycles).
//    mem_ready=1 -> mem_valid<=0, rr_ptr<=(grant+1)%NUM_REQ -> DRAIN.
//    req_valid[grant]=0 and mem_ready=0 (requester abandoned) -> ABORT; mem_valid stays 1.
//    mem_ready and withdrawal same cycle: completion wins, ready pulse still issued -> DRAIN.
//  ABORT: mem_valid held 1 until mem_ready; that data discarded, no req_ready; then mem_valid<=0,
//    rr_ptr advances as normal -> DRAIN. New requests wait.
//  DRAIN: one cycle, all req_valid ignored (absorbs requester's registered valid deassert) -> IDLE.
//  Min cycles between back-to-back grants: mem_ready cycle, DRAIN, IDLE grant cycle.
//  mem_ready in IDLE/DRAIN: ignored, no req_ready. Never more than one req_ready bit set.
//  req_addr of non-granted requesters never affects mem_addr; mem_addr stable while mem_valid=1.
//  rr_ptr wraps NUM_REQ-1 -> 0; unused when FIXED_PRIO=1.
// STRUCTURE
//  Header mem_arb_defs.vh: state encodings (2-bit) ARB_IDLE/ARB_BUSY/ARB_ABORT/ARB_DRAIN.
//  Sub-module rr_pick #(N): comb., inputs valid[N] and ptr, outputs any and idx; FIXED_PRIO drives ptr=0.
//  Top: FSM, grant/ptr/addr regs, req_ready decode, rdata pass-through.
// TESTING
//  1 req0 valid addr 0x100, mem_ready 3 cyc after mem_valid -> mem_addr=0x100, req_ready=2'b01 one cycle, req_rdata=mem_rdata.
//  2 RR, both valid held, each drops valid after its ready -> grants 0,1,0,1; mem_addr tracks requester addrs 0x200/0x300.
//  3 req1 granted, req1 drops valid 1 cyc later, mem_ready 2 cyc after -> req_ready stays 0; mem_valid 0 next cycle; req0 then granted.
//  4 resetn low mid-BUSY with mem_valid=1 -> mem_valid=0 and req_ready=0 immediately; after release req0 wins first.
//  5 mem_ready pulsed in IDLE, no requests -> no req_ready, state stays IDLE.
//  6 FIXED_PRIO=1, both valid continuously re-requesting -> req0 granted each time; req1 only after req0 idles.

Source files
------------

// File: rtl/mem_line_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_line_arbiter_pkg
// Brief  : Shared types for the memory line arbiter. Holds the arbiter FSM
//          state encoding (2-bit) used by the top level.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_line_arbiter_pkg;

  localparam int ARB_STATE_W = 2;

  // IDLE  : waiting for any requester
  // BUSY  : memory transaction in flight for the granted requester
  // ABORT : requester withdrew; finish the memory beat and drop the data
  // DRAIN : one dead cycle so a requester's registered valid can fall
  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

endpackage : mem_line_arbiter_pkg
`default_nettype wire

// File: rtl/mem_line_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotating picker. Returns the first asserted bit of
//          valid at or after ptr, wrapping past N-1 back to 0. Driving ptr=0
//          turns it into a lowest-index-wins fixed-priority picker.
// Ports  : valid [N]  request vector
//          ptr   [PW] starting search position
//          any        at least one valid bit set
//          idx   [PW] index of the chosen requester (0 when any=0)
// Rev    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore the winner.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    sum  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      cand = sum[PW-1:0];
      if (valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_line_arbiter
// Brief  : Shares one line-wide memory read port between NUM_REQ cache refill
//          requesters. One outstanding memory transaction at a time, with
//          round-robin (FIXED_PRIO=0) or lowest-index (FIXED_PRIO=1) grant.
// Ports  : clk, resetn (async, active low)
//          req_valid/req_addr  in   requester line read requests
//          req_ready           out  1-cycle completion pulse to the grantee
//          req_rdata           out  line data, broadcast, valid with req_ready
//          mem_valid/mem_addr  out  memory request, address latched at grant
//          mem_ready/mem_rdata in   memory completion pulse and line data
// Rev    : 1.0 - initial release
// ============================================================================
module mem_line_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int LINE_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [LINE_WIDTH-1:0]         req_rdata,
  output logic                          mem_valid,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_ready,
  input  logic [LINE_WIDTH-1:0]         mem_rdata
);

  import mem_line_arbiter_pkg::*;

  localparam int            PW       = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_valid_q, mem_valid_d;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [PW-1:0]         pick_ptr;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;
  logic [PW-1:0]         next_ptr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Fixed priority is the rotating picker anchored at index 0.
  assign pick_ptr = (FIXED_PRIO != 0) ? '0 : rr_ptr_q;
  assign next_ptr = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (pick_ptr),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_valid_d = mem_valid_q;
    req_ready   = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_idx;
          mem_addr_d  = addr_arr[pick_idx];
          mem_valid_d = 1'b1;
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Completion takes precedence over a same-cycle withdrawal.
        if (mem_ready) begin
          req_ready[grant_q] = 1'b1;
          mem_valid_d        = 1'b0;
          rr_ptr_d           = next_ptr;
          state_d            = ARB_DRAIN;
        end else if (!req_valid[grant_q]) begin
          state_d = ARB_ABORT;
        end
      end
      ARB_ABORT: begin
        // The memory beat must still be consumed; its data goes nowhere.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rr_ptr_d    = next_ptr;
          state_d     = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign req_rdata = mem_rdata;

endmodule : mem_line_arbiter
`default_nettype wire

// File: tb/tb_mem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_line_arbiter
// Brief  : Self-checking bench for mem_line_arbiter. Index 0 of every signal
//          array is a round-robin instance, index 1 a fixed-priority one.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_line_arbiter;

  logic        clk = 1'b0;
  logic        resetn;

  logic [1:0]  rv [2];
  logic [63:0] ra [2];
  logic        mr [2];
  logic [63:0] md [2];
  logic [1:0]  rr_o [2];
  logic [63:0] rd_o [2];
  logic        mv_o [2];
  logic [31:0] ma_o [2];

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m [2];

  always #5 clk = ~clk;

  mem_line_arbiter #(.NUM_REQ(2), .LINE_WIDTH(64), .ADDR_WIDTH(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .resetn(resetn),
    .req_valid(rv[0]), .req_addr(ra[0]), .req_ready(rr_o[0]), .req_rdata(rd_o[0]),
    .mem_valid(mv_o[0]), .mem_addr(ma_o[0]), .mem_ready(mr[0]), .mem_rdata(md[0])
  );

  mem_line_arbiter #(.NUM_REQ(2), .LINE_WIDTH(64), .ADDR_WIDTH(32), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .resetn(resetn),
    .req_valid(rv[1]), .req_addr(ra[1]), .req_ready(rr_o[1]), .req_rdata(rd_o[1]),
    .mem_valid(mv_o[1]), .mem_addr(ma_o[1]), .mem_ready(mr[1]), .mem_rdata(md[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Winner by the arbitration rules: RR = first valid at/after pointer,
  // fixed = lowest valid index.
  function automatic int winner(input int d, input logic [1:0] vm);
    if (d == 1) return vm[0] ? 0 : 1;
    for (int k = 0; k < 2; k++) begin
      if (vm[(ptr_m[0] + k) % 2]) return (ptr_m[0] + k) % 2;
    end
    return 0;
  endfunction

  // One complete transaction: IDLE cycle with requests, lat BUSY cycles with
  // mem_ready on the last one, then the DRAIN cycle. ab>0 drops the winner's
  // valid from cycle ab onward (ab<lat aborts, ab==lat is a same-cycle drop).
  task automatic txn(input int d, input logic [1:0] vm, input logic [63:0] a0,
                     input int lat, input int ab, input bit hold);
    int          w;
    logic [31:0] ea;
    bit          aborted;
    w = winner(d, vm);
    @(negedge clk);
    rv[d] = vm; ra[d] = a0; mr[d] = 1'($urandom_range(0, 1)); md[d] = {$urandom, $urandom};
    #1;
    chk("idle_mem_valid", 64'(mv_o[d]), 64'd0);
    chk("idle_req_ready", 64'(rr_o[d]), 64'd0);
    ea      = (w == 0) ? a0[31:0] : a0[63:32];
    aborted = (ab > 0) && (ab < lat);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      ra[d] = {$urandom, $urandom};
      md[d] = {$urandom, $urandom};
      if (ab > 0 && c >= ab) rv[d][w] = 1'b0;
      mr[d] = (c == lat);
      #1;
      chk("busy_mem_valid", 64'(mv_o[d]), 64'd1);
      chk("busy_mem_addr", 64'(ma_o[d]), 64'(ea));
      chk("busy_req_ready", 64'(rr_o[d]),
          (c == lat && !aborted) ? 64'(2'b01 << w) : 64'd0);
      chk("busy_req_rdata", rd_o[d], md[d]);
    end
    @(negedge clk);
    mr[d] = 1'($urandom_range(0, 1));
    md[d] = {$urandom, $urandom};
    if (!hold) rv[d][w] = 1'b0;
    #1;
    chk("drain_mem_valid", 64'(mv_o[d]), 64'd0);
    chk("drain_req_ready", 64'(rr_o[d]), 64'd0);
    ptr_m[d] = (w + 1) % 2;
  endtask

  initial begin
    int          lat;
    int          ab;
    logic [1:0]  vm;
    logic [31:0] ea;
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0; ra[d] = '0; mr[d] = 1'b0; md[d] = '0; ptr_m[d] = 0;
    end
    resetn = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_mem_valid", 64'(mv_o[d]), 64'd0);
      chk("rst_mem_addr", 64'(ma_o[d]), 64'd0);
      chk("rst_req_ready", 64'(rr_o[d]), 64'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // mem_ready pulses in IDLE with no requests
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mr[0] = ~mr[0]; md[0] = {$urandom, $urandom};
      #1;
      chk("idle_pulse_ready", 64'(rr_o[0]), 64'd0);
      chk("idle_pulse_valid", 64'(mv_o[0]), 64'd0);
    end

    // Single requester 0 at 0x100, ready on third BUSY cycle
    txn(0, 2'b01, {32'h0, 32'h100}, 3, 0, 1'b0);
    // Bring pointer back to 0, then alternate with both held
    txn(0, 2'b10, {32'h300, 32'h200}, 1, 0, 1'b0);
    for (int i = 0; i < 4; i++) txn(0, 2'b11, {32'h300, 32'h200}, 2, 0, 1'b0);

    // Requester 1 abandons one cycle in; memory completes two cycles later
    txn(0, 2'b10, {32'h400, 32'h0}, 3, 1, 1'b0);
    txn(0, 2'b11, {32'h600, 32'h500}, 2, 0, 1'b0);
    // Withdrawal on the completion cycle still gets the pulse
    txn(0, 2'b01, {32'h0, 32'h700}, 2, 2, 1'b0);

    // Asynchronous reset in the middle of BUSY (pointer now favours req1)
    @(negedge clk);
    rv[0] = 2'b11; ra[0] = {32'hAAA0, 32'hBBB0}; mr[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_mem_valid", 64'(mv_o[0]), 64'd1);
    chk("pre_rst_mem_addr", 64'(ma_o[0]), 64'h0000_AAA0);
    @(negedge clk);
    resetn = 1'b0; mr[0] = 1'b1;
    #1;
    chk("async_rst_mem_valid", 64'(mv_o[0]), 64'd0);
    chk("async_rst_req_ready", 64'(rr_o[0]), 64'd0);
    @(negedge clk);
    resetn = 1'b1; mr[0] = 1'b0; rv[0] = 2'b00;
    ptr_m[0] = 0;
    txn(0, 2'b11, {32'hC00, 32'hD00}, 1, 0, 1'b0);

    // Randomised round-robin traffic
    for (int i = 0; i < 25; i++) begin
      vm  = 2'($urandom_range(1, 3));
      lat = int'($urandom_range(1, 5));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat)) : 0;
      txn(0, vm, {$urandom, $urandom}, lat, ab, 1'($urandom_range(0, 1)));
    end

    // Fixed priority: req0 keeps re-requesting and always wins
    for (int i = 0; i < 3; i++) txn(1, 2'b11, {32'h900, 32'h800}, int'($urandom_range(1, 4)), 0, 1'b1);
    txn(1, 2'b10, {32'h900, 32'h800}, 2, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      vm  = 2'($urandom_range(1, 3));
      lat = int'($urandom_range(1, 4));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : 0;
      txn(1, vm, {$urandom, $urandom}, lat, ab, 1'($urandom_range(0, 1)));
    end

    // Fixed-priority instance observed directly after a hold-valid grant
    @(negedge clk);
    rv[1] = 2'b11; ra[1] = {32'h1234, 32'h5678}; mr[1] = 1'b0;
    ea = 32'h5678;
    @(negedge clk);
    #1;
    chk("fp_grant_addr", 64'(ma_o[1]), 64'(ea));
    @(negedge clk);
    mr[1] = 1'b1;
    #1;
    chk("fp_grant_ready", 64'(rr_o[1]), 64'h1);
    @(negedge clk);
    mr[1] = 1'b0; rv[1] = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_line_arbiter
`default_nettype wire
